// File: rtl/operand_feeder_pkg.sv
// Shared widths, FIFO geometry and FSM encoding for the operand feeder.
// Pure declarations; no latency or backpressure of its own.
package operand_feeder_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int DATA_W     = 8;
  localparam int INSTR_W    = 3;
  localparam int CNT_W      = 4;
  localparam int PAIR_W     = 2 * DATA_W;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FILL_W     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ONE_LEFT = 3'd2,
    STREAM   = 3'd3,
    WAIT_FIN = 3'd4
  } state_t;

  function automatic logic count_ok(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(1)) && (c <= CNT_W'(FIFO_DEPTH));
  endfunction

endpackage

// File: rtl/operand_feeder_if.sv
// Push, command and downstream operand bundle of the operand feeder.
// master drives pushes, commands and finish; slave is the feeder itself.
interface operand_feeder_if;
  import operand_feeder_pkg::*;

  logic                push;
  logic [DATA_W-1:0]   push_a;
  logic [DATA_W-1:0]   push_b;
  logic                full;
  logic                overflow;
  logic                cmd_go;
  logic [CNT_W-1:0]    cmd_count;
  logic [INSTR_W-1:0]  cmd_instr;
  logic                busy;
  logic                start;
  logic                valid;
  logic                one_left;
  logic [DATA_W-1:0]   Data_A;
  logic [DATA_W-1:0]   Data_B;
  logic [INSTR_W-1:0]  instruction;
  logic                finish;

  modport master (
    output push, push_a, push_b, cmd_go, cmd_count, cmd_instr, finish,
    input  full, overflow, busy, start, valid, one_left, Data_A, Data_B, instruction
  );

  modport slave (
    input  push, push_a, push_b, cmd_go, cmd_count, cmd_instr, finish,
    output full, overflow, busy, start, valid, one_left, Data_A, Data_B, instruction
  );

endinterface

// File: rtl/operand_fifo.sv
// 8x16 operand-pair FIFO with registered full/empty; a write is visible one cycle later.
// Writes while full are dropped even with a same-cycle read; head_nxt previews next cycle's head.
module operand_fifo
  import operand_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [PAIR_W-1:0] wdata,
  input  logic              rd,
  output logic              full,
  output logic              empty,
  output logic              avail_nxt,
  output logic [PAIR_W-1:0] head_nxt
);

  logic [PAIR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic              wr_en, rd_en;

  assign wr_en      = wr && !full;
  assign rd_en      = rd && !empty;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(rd_en);
  assign fill_nxt   = fill + FILL_W'(wr_en) - FILL_W'(rd_en);
  assign avail_nxt  = (fill_nxt != '0);

  // When the FIFO drains to empty this cycle, the incoming write lands at the new head slot.
  assign head_nxt = (wr_en && ((fill - FILL_W'(rd_en)) == '0)) ? wdata : mem[rd_ptr_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_en);
      rd_ptr <= rd_ptr_nxt;
      fill   <= fill_nxt;
      full   <= (fill_nxt == FILL_W'(FIFO_DEPTH));
      empty  <= (fill_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/operand_feeder.sv
// Streams buffered operand pairs to a max-finder under a start/one_left/valid protocol; all outputs registered.
// A beat is issued whenever the FIFO is non-empty during STREAM; an empty FIFO stalls with valid low.
module operand_feeder
  import operand_feeder_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  operand_feeder_if.slave bus
);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    run_cnt, run_cnt_nxt;
  logic [CNT_W-1:0]    issued, issued_nxt;
  logic                accept, beat, last_beat;
  logic                start_d, busy_d, valid_d, one_left_d;
  logic                start_q, busy_q, valid_q, one_left_q, overflow_q;
  logic [DATA_W-1:0]   data_a_q, data_b_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                fifo_full, fifo_empty, fifo_avail_nxt;
  logic [PAIR_W-1:0]   fifo_head_nxt;

  operand_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (bus.push),
    .wdata     ({bus.push_a, bus.push_b}),
    .rd        (beat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .avail_nxt (fifo_avail_nxt),
    .head_nxt  (fifo_head_nxt)
  );

  assign accept    = (state == IDLE) && bus.cmd_go && count_ok(bus.cmd_count);
  // The visible valid beat is the pop: outputs are pre-computed one cycle ahead.
  assign beat      = valid_q && !fifo_empty;
  assign last_beat = beat && ((issued + CNT_W'(1)) == run_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = START;
      START:    state_nxt = (run_cnt == CNT_W'(1)) ? ONE_LEFT : STREAM;
      ONE_LEFT: state_nxt = STREAM;
      STREAM:   if (last_beat) state_nxt = WAIT_FIN;
      WAIT_FIN: if (bus.finish) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run_cnt_nxt = accept ? bus.cmd_count : run_cnt;
    issued_nxt  = accept ? '0 : issued + CNT_W'(beat);
    start_d     = (state_nxt == START);
    busy_d      = (state_nxt != IDLE);
    valid_d     = (state_nxt == STREAM) && fifo_avail_nxt;
    // Beat number issued_nxt+1 is the (count-1)-th pair.
    one_left_d  = (state_nxt == ONE_LEFT) ||
                  (valid_d && (run_cnt_nxt >= CNT_W'(2)) &&
                   ((issued_nxt + CNT_W'(2)) == run_cnt_nxt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt    <= '0;
      issued     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      one_left_q <= 1'b0;
      overflow_q <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      instr_q    <= '0;
    end else begin
      run_cnt    <= run_cnt_nxt;
      issued     <= issued_nxt;
      start_q    <= start_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      one_left_q <= one_left_d;
      overflow_q <= bus.push && fifo_full;
      if (valid_d) {data_a_q, data_b_q} <= fifo_head_nxt;
      if (accept)  instr_q <= bus.cmd_instr;
    end
  end

  assign bus.start       = start_q;
  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.one_left    = one_left_q;
  assign bus.overflow    = overflow_q;
  assign bus.full        = fifo_full;
  assign bus.Data_A      = data_a_q;
  assign bus.Data_B      = data_b_q;
  assign bus.instruction = instr_q;

endmodule
